// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a power-of-two FIFO feeding a start/data/parity/stop serialiser.
// TxD is registered so the line never glitches; all state uses a synchronous active-high reset.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        TxD_data,
  input  logic                        TxD_valid,
  output logic                        TxD_ready,
  output logic                        TxD,
  output logic                        TxD_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int unsigned DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned BW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [BW-1:0] BaudLast = BW'(DIV - 1);
  localparam logic [3:0]    DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]    StopLast = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   Full     = (AW + 1)'(FIFO_DEPTH);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: clock divider below 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_overflow;
  logic                 w_wr, w_pop, w_full, w_empty;
  logic [DATA_BITS-1:0] w_head;

  state_e               r_state, w_state_d;
  logic [BW-1:0]        r_baud, w_baud_d;
  logic [3:0]           r_bit, w_bit_d;
  logic [DATA_BITS-1:0] r_shift, w_shift_d;
  logic                 r_par, w_par_d;
  logic                 r_txd, w_txd_d;
  logic                 w_baud_end;

  assign w_full     = (r_count == Full);
  assign w_empty    = (r_count == '0);
  assign w_wr       = TxD_valid && !w_full && !rst;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_baud_end = (r_baud == BaudLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      r_overflow <= TxD_valid && w_full;
    end
  end

  // Storage needs no reset: clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= TxD_data;
  end

  always_comb begin
    w_state_d = r_state;
    w_baud_d  = r_baud + 1'b1;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_par_d   = r_par;
    w_txd_d   = r_txd;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_baud_d = '0;
        w_txd_d  = 1'b1;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StStart;
          w_txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (w_baud_end) begin
          w_state_d = StData;
          w_baud_d  = '0;
          w_bit_d   = '0;
          w_txd_d   = r_shift[0];
        end
      end
      StData: begin
        if (w_baud_end) begin
          w_baud_d = '0;
          if (r_bit == DataLast) begin
            w_bit_d = '0;
            if (PARITY != 0) begin
              w_state_d = StParity;
              w_txd_d   = r_par;
            end else begin
              w_state_d = StStop;
              w_txd_d   = 1'b1;
            end
          end else begin
            w_bit_d   = r_bit + 1'b1;
            w_shift_d = r_shift >> 1;
            w_txd_d   = r_shift[1];
          end
        end
      end
      StParity: begin
        if (w_baud_end) begin
          w_state_d = StStop;
          w_baud_d  = '0;
          w_bit_d   = '0;
          w_txd_d   = 1'b1;
        end
      end
      StStop: begin
        if (w_baud_end) begin
          w_baud_d = '0;
          if (r_bit == StopLast) begin
            w_bit_d = '0;
            // Chain straight into the next frame when data is waiting.
            if (!w_empty) begin
              w_pop     = 1'b1;
              w_state_d = StStart;
              w_txd_d   = 1'b0;
            end else begin
              w_state_d = StIdle;
              w_txd_d   = 1'b1;
            end
          end else begin
            w_bit_d = r_bit + 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_txd_d   = 1'b1;
      end
    endcase
    if (w_pop) begin
      w_shift_d = w_head;
      w_par_d   = (PARITY == 1) ? ~^w_head : ^w_head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_par   <= w_par_d;
      r_txd   <= w_txd_d;
    end
  end

  assign TxD        = r_txd;
  assign TxD_ready  = !w_full;
  assign TxD_busy   = !((r_state == StIdle) && w_empty);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameter sets, each with a driver that keeps a frame-timing
// model and a scoreboard, plus a monitor that checks every cycle of the serial line.
module tb_uart_tx_fifo;
  localparam int NCFG  = 4;
  localparam int CLKF  = 50_000_000;
  localparam int BAUDR = 5_000_000;
  localparam int DIV   = 10;

  function automatic int cfg_db(input int i);
    case (i) 0: return 8; 1: return 9; 2: return 7; default: return 5; endcase
  endfunction
  function automatic int cfg_par(input int i);
    case (i) 0: return 0; 1: return 2; 2: return 1; default: return 0; endcase
  endfunction
  function automatic int cfg_sb(input int i);
    case (i) 0: return 1; 1: return 2; 2: return 1; default: return 2; endcase
  endfunction
  function automatic int cfg_dp(input int i);
    case (i) 0: return 4; 1: return 4; 2: return 8; default: return 2; endcase
  endfunction

  typedef struct {
    logic [8:0] d;
    int         s;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int DB  = cfg_db(gi);
    localparam int PAR = cfg_par(gi);
    localparam int SB  = cfg_sb(gi);
    localparam int DP  = cfg_dp(gi);
    localparam int NB  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int L   = NB * DIV;
    localparam int CW  = $clog2(DP) + 1;
    localparam logic [8:0] MASK = 9'((1 << DB) - 1);

    logic          rst   = 1'b1;
    logic          valid = 1'b0;
    logic [DB-1:0] data  = '0;
    logic          ready, txd, busy, ovf;
    logic [CW-1:0] count;

    uart_tx_fifo #(
      .CLK_FREQ  (CLKF),
      .BAUD      (BAUDR),
      .DATA_BITS (DB),
      .PARITY    (PAR),
      .STOP_BITS (SB),
      .FIFO_DEPTH(DP)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .TxD_data  (data),
      .TxD_valid (valid),
      .TxD_ready (ready),
      .TxD       (txd),
      .TxD_busy  (busy),
      .fifo_count(count),
      .overflow  (ovf)
    );

    exp_t sb[$];
    int   starts[$];
    int   prev_end = 0;
    int   last_s = 0;
    bit   exp_ovf = 1'b0;

    // Line levels of one frame, one entry per bit time; unused high bits stay 1.
    function automatic logic [15:0] frame_of(input logic [8:0] d);
      logic [15:0] f;
      int ones;
      f    = '1;
      f[0] = 1'b0;
      for (int j = 0; j < DB; j++) f[1 + j] = d[j];
      ones = $countones(d[DB-1:0]);
      if (PAR == 2) f[1 + DB] = (ones % 2 == 1);
      if (PAR == 1) f[1 + DB] = (ones % 2 == 0);
      return f;
    endfunction

    function automatic logic [8:0] rnd();
      return 9'($urandom) & MASK;
    endfunction

    // One cycle: check status outputs against the model, then drive the next inputs.
    task automatic step(input bit v, input logic [8:0] d, input bit r, output bit acc);
      int   occ;
      exp_t e;
      @(negedge clk);
      while (starts.size() > 0 && starts[0] <= cyc) void'(starts.pop_front());
      occ = starts.size();
      chk($sformatf("cfg%0d ready", gi), int'(ready), int'(occ < DP));
      chk($sformatf("cfg%0d fifo_count", gi), int'(count), occ);
      chk($sformatf("cfg%0d busy", gi), int'(busy), int'(occ > 0 || cyc < prev_end));
      chk($sformatf("cfg%0d overflow", gi), int'(ovf), int'(exp_ovf));
      #1;
      rst     = r;
      valid   = v;
      data    = d[DB-1:0];
      acc     = 1'b0;
      exp_ovf = 1'b0;
      if (r) begin
        starts.delete();
        sb.delete();
        prev_end = 0;
      end else if (v && occ < DP) begin
        acc      = 1'b1;
        last_s   = (cyc + 2 > prev_end) ? cyc + 2 : prev_end;
        prev_end = last_s + L;
        starts.push_back(last_s);
        e.d = d & MASK;
        e.s = last_s;
        sb.push_back(e);
      end else begin
        exp_ovf = v;
      end
    endtask

    task automatic send(input logic [8:0] d);
      bit a;
      do step(1'b1, d, 1'b0, a); while (!a);
    endtask

    task automatic drain();
      bit a;
      while (cyc < prev_end + 2) step(1'b0, '0, 1'b0, a);
    endtask

    initial begin
      bit acc;
      int s0;
      repeat (3) step(1'b0, '0, 1'b1, acc);
      repeat (4) step(1'b0, '0, 1'b0, acc);
      send((gi == 1) ? 9'h007 : (gi == 3) ? 9'h01F : 9'h0A5);
      drain();
      // Valid held through a burst: one byte leaves at once, DP fill the FIFO, one overflows.
      for (int k = 0; k < DP + 1; k++) send(rnd());
      step(1'b1, rnd(), 1'b0, acc);
      drain();
      for (int k = 0; k < 2 * DP + 2; k++) send(rnd());
      drain();
      for (int k = 0; k < 600; k++) begin
        step(($urandom_range(0, 15) < ((k < 300) ? 1 : 12)), rnd(), 1'b0, acc);
      end
      drain();
      send(rnd());
      s0 = last_s;
      send(rnd());
      send(rnd());
      while (cyc < s0 + DIV * 4 + 3) step(1'b0, '0, 1'b0, acc);
      step(1'b1, rnd(), 1'b1, acc);
      repeat (3 * L) step(1'b0, '0, 1'b0, acc);
      send(rnd());
      drain();
      n_done++;
    end

    initial begin
      bit          in_f;
      int          fs, off, glitch;
      logic [15:0] cur, got;
      exp_t        e;
      in_f = 1'b0;
      fs = 0;
      glitch = 0;
      cur = '1;
      got = '1;
      forever begin
        @(negedge clk);
        if (rst) begin
          in_f = 1'b0;
          chk($sformatf("cfg%0d txd_in_reset", gi), int'(txd), 1);
        end else if (in_f) begin
          off = cyc - fs;
          if (txd != cur[off / DIV]) glitch++;
          if (off % DIV == DIV / 2) got[off / DIV] = txd;
          if (off == L - 1) begin
            chk($sformatf("cfg%0d frame_bits", gi), int'(got), int'(cur));
            chk($sformatf("cfg%0d frame_glitches", gi), glitch, 0);
            in_f = 1'b0;
          end
        end else if (txd == 1'b0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cfg%0d unexpected_start: got start bit at cycle %0d, expected idle",
                     gi, cyc);
          end else begin
            e = sb.pop_front();
            chk($sformatf("cfg%0d start_cycle", gi), cyc, e.s);
            cur    = frame_of(e.d);
            got    = '1;
            fs     = cyc;
            glitch = 0;
            in_f   = 1'b1;
          end
        end else if (sb.size() > 0 && cyc > sb[0].s + 1) begin
          chk($sformatf("cfg%0d missing_start", gi), cyc, sb[0].s);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    wait (n_done == NCFG);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: got no completion after 60000 cycles, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, meaning line rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..9.
REQ-004 Parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1, meaning stop bits per frame, legal 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16, meaning TX FIFO entries, power of 2, at least 2.
REQ-007 Port clk  input  1  system clock, all logic on the rising edge.
REQ-008 Port rst  input  1  reset, synchronous, active-high.
REQ-009 Port TxD_data  input  DATA_BITS  byte to transmit.
REQ-010 Port TxD_valid  input  1  TxD_data is valid this cycle.
REQ-011 Port TxD_ready  output  1  FIFO can accept a byte; equals not fifo_full.
REQ-012 Port TxD  output  1  serial line, idle high, registered.
REQ-013 Port TxD_busy  output  1  frame in progress or FIFO non-empty.
REQ-014 Port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 Port overflow  output  1  one-cycle pulse on a write attempt while full.

Function
REQ-016 DIV SHALL be computed at elaboration as (CLK_FREQ + BAUD/2) / BAUD; a DIV below 2 SHALL fail elaboration.
REQ-017 A write SHALL occur on an edge where TxD_valid and TxD_ready are both high; TxD_data is captured into the FIFO.
REQ-018 On a write while full, the data SHALL be dropped, the FIFO left unchanged, and overflow pulsed high for exactly one cycle.
REQ-019 A simultaneous write and pop SHALL leave fifo_count unchanged. The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE -> START: on the first edge on which the FIFO is non-empty. The head entry is popped and latched into a shift register on the same edge.
REQ-022 The baud counter SHALL restart at 0 on entry to START, so every bit lasts exactly DIV clk cycles.
REQ-023 START SHALL drive TxD=0 for DIV cycles, then move to DATA.
REQ-024 DATA SHALL send DATA_BITS bits, LSB first, with DIV cycles each.
  - After the last bit: go to PARITY if PARITY != 0, else go to STOP.
REQ-025 PARITY SHALL send one bit for DIV cycles.
  - Even parity: XOR of the data bits.
  - Odd parity: inverted XOR of the data bits.
REQ-026 STOP SHALL drive TxD=1 for STOP_BITS×DIV cycles.
  - At the end, if the FIFO is non-empty: pop and go directly to START on the same edge, with no idle gap.
  - Otherwise: go to IDLE.
REQ-027 Latency: a byte written on edge N into an empty FIFO with the FSM in IDLE SHALL produce the start bit falling edge on TxD at edge N+1.
  - Reason: the write at edge N and the IDLE->START transition at edge N+1 are sequential, since the FIFO is empty at edge N.
REQ-028 TxD_busy SHALL be low only when the FSM is in IDLE and the FIFO is empty.
REQ-029 Changes on TxD_data or TxD_valid during a frame SHALL NOT affect the frame being shifted out.
REQ-030 When DATA_BITS=9 and PARITY!=0, all 9 bits SHALL be included in the parity.

Reset
REQ-031 While rst is high, on each edge the block SHALL apply these values:
  - FSM = IDLE, baud and bit counters = 0.
  - FIFO pointers = 0, fifo_count = 0.
  - TxD = 1, TxD_ready = 1, TxD_busy = 0, overflow = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame and discard FIFO contents.
  - TxD SHALL be high from the next edge.
  - No partial bit is stretched and no trailing stop bit is generated.
REQ-033 A write attempted on an edge with rst high SHALL be ignored.

Verification (CLK_FREQ=50_000_000, BAUD=5_000_000 → DIV=10, unless stated)
REQ-034 8N1: write 0xA5 at edge N.
  - TxD low from N+1 for 10 cycles.
  - Then the bits 1,0,1,0,0,1,0,1 for 10 cycles each, then high for 10 cycles.
  - TxD_busy falls at edge N+101.
REQ-035 PARITY=2, STOP_BITS=2: write 0x07.
  - Expect the parity bit = 1 for 10 cycles, then 20 cycles high.
  - With PARITY=1, the parity bit = 0.
REQ-036 FIFO_DEPTH=4: hold TxD_valid high with 6 bytes while TxD is idle.
  - Exactly 5 are accepted: 1 is popped at once and 4 fill the FIFO.
  - TxD_ready falls.
  - One overflow pulse occurs when the 6th byte is presented against a full FIFO.
  - The 5 accepted frames are sent back-to-back with no idle gap.
REQ-037 Assert rst for 1 cycle at the 4th data bit of a frame, with 2 bytes queued.
  - TxD = 1 and fifo_count = 0 from the next edge.
  - No further frames are sent.
REQ-038 Write and pop on the same edge with fifo_count=3: fifo_count stays 3. Continuous writes across 2×FIFO_DEPTH frames verify pointer wrap and data order.
REQ-039 DATA_BITS=5, PARITY=0, write 0x1F: frame length is 70 cycles (1+5+1 bits, each 10 cycles).
